// File: rtl/reg_bank_arbiter_if.sv
// Request/response bundle between the requesters and the shared-register arbiter.
// The arbiter takes the slave side; the requester side is the master.
interface reg_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic [15:0]           wr_count;

   modport master (output req, wdata, input gnt, ack, q, busy, wr_count);
   modport slave  (input req, wdata, output gnt, ack, q, busy, wr_count);
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that grants one requester at a time write access to a shared
// register: IDLE picks a winner, GRANT samples its data, COMMIT acks for one cycle.
module reg_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   reg_bank_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     win_q, win_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic              busy_q, busy_d;
   logic [15:0]       wr_count_q, wr_count_d;

   logic [PW-1:0]     pick;
   logic              pick_vld;
   logic [NREQ-1:0]   pick_oh;
   logic [NREQ-1:0]   win_oh;
   int                idx;

   // First set req bit at or above ptr, wrapping at NREQ-1.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!pick_vld && bus.req[idx]) begin
            pick_vld = 1'b1;
            pick     = PW'(idx);
         end
      end
   end

   assign pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << pick;
   assign win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << win_q;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      q_d        = q_q;
      wr_count_d = wr_count_q;
      gnt_d      = '0;
      ack_d      = '0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = GRANT;
               win_d   = pick;
               gnt_d   = pick_oh;
            end
         end
         GRANT: begin
            // Dropping req while granted aborts without touching q, ptr or count.
            if (bus.req[win_q]) begin
               state_d = COMMIT;
               q_d     = bus.wdata[win_q*WIDTH +: WIDTH];
               gnt_d   = win_oh;
               ack_d   = win_oh;
            end else begin
               state_d = IDLE;
            end
         end
         COMMIT: begin
            state_d    = IDLE;
            ptr_d      = (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);
            wr_count_d = wr_count_q + 16'd1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         win_q      <= '0;
         gnt_q      <= '0;
         ack_q      <= '0;
         q_q        <= '0;
         busy_q     <= 1'b0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         q_q        <= q_d;
         busy_q     <= busy_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.ack      = ack_q;
   assign bus.q        = q_q;
   assign bus.busy     = busy_q;
   assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed vector table, hand sequences for
// reset/abort/wrap/data-hold corners, then random traffic against a transaction model.
module tb_reg_bank_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   reg_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   reg_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Transaction-level reference: a pending transaction with an age of 1 (granted)
   // or 2 (committed); everything else follows from the arbitration rules.
   bit         m_in;
   int         m_age;
   int         m_win;
   int         m_ptr;
   logic [7:0] m_q;
   int         m_cnt;

   task automatic model_reset();
      m_in = 0; m_age = 0; m_win = 0; m_ptr = 0; m_q = '0; m_cnt = 0;
   endtask

   task automatic model_edge();
      logic [NREQ-1:0]       r;
      logic [NREQ*WIDTH-1:0] w;
      r = bus.req;
      w = bus.wdata;
      if (!m_in) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!m_in && r[(m_ptr + k) % NREQ]) begin
               m_in = 1; m_age = 1; m_win = (m_ptr + k) % NREQ;
            end
         end
      end else if (m_age == 1) begin
         if (r[m_win]) begin
            m_q = w[m_win*WIDTH +: WIDTH];
            m_age = 2;
         end else begin
            m_in = 0;
         end
      end else begin
         m_cnt = (m_cnt + 1) % 65536;
         m_ptr = (m_win + 1) % NREQ;
         m_in  = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req   = '0;
      bus.wdata = '0;
      #2 reset = 1'b0;
      model_reset();
      #3;
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_gnt"},  32'(bus.gnt),  m_in ? 32'(1 << m_win) : 32'd0);
      chk({tag, "_ack"},  32'(bus.ack),  (m_in && m_age == 2) ? 32'(1 << m_win) : 32'd0);
      chk({tag, "_q"},    32'(bus.q),    32'(m_q));
      chk({tag, "_busy"}, 32'(bus.busy), 32'(m_in));
      chk({tag, "_cnt"},  32'(bus.wr_count), 32'(m_cnt));
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [31:0] wdata;
      logic [3:0]  gnt;
      logic [3:0]  ack;
      logic [7:0]  q;
      logic        busy;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int         order[$];
      logic [3:0] prev_gnt;
      int         viol;
      logic [3:0] g;

      tbl[0]  = '{4'b0001, 32'h0000_00A5, 4'b0001, 4'b0000, 8'h00, 1'b1, 16'd0};
      tbl[1]  = '{4'b0001, 32'h0000_00A5, 4'b0001, 4'b0001, 8'hA5, 1'b1, 16'd0};
      tbl[2]  = '{4'b0001, 32'h0000_00A5, 4'b0000, 4'b0000, 8'hA5, 1'b0, 16'd1};
      tbl[3]  = '{4'b0000, 32'h0000_00A5, 4'b0000, 4'b0000, 8'hA5, 1'b0, 16'd1};
      tbl[4]  = '{4'b0100, 32'h0000_0000, 4'b0100, 4'b0000, 8'hA5, 1'b1, 16'd1};
      tbl[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 8'hA5, 1'b0, 16'd1};
      tbl[6]  = '{4'b0100, 32'h003C_0000, 4'b0100, 4'b0000, 8'hA5, 1'b1, 16'd1};
      tbl[7]  = '{4'b0100, 32'h003C_0000, 4'b0100, 4'b0100, 8'h3C, 1'b1, 16'd1};
      tbl[8]  = '{4'b0000, 32'h003C_0000, 4'b0000, 4'b0000, 8'h3C, 1'b0, 16'd2};
      tbl[9]  = '{4'b1010, 32'hEE00_DD00, 4'b1000, 4'b0000, 8'h3C, 1'b1, 16'd2};
      tbl[10] = '{4'b1010, 32'hEE00_DD00, 4'b1000, 4'b1000, 8'hEE, 1'b1, 16'd2};
      tbl[11] = '{4'b1010, 32'hEE00_DD00, 4'b0000, 4'b0000, 8'hEE, 1'b0, 16'd3};
      tbl[12] = '{4'b1010, 32'hEE00_DD00, 4'b0010, 4'b0000, 8'hEE, 1'b1, 16'd3};
      tbl[13] = '{4'b1010, 32'hEE00_DD00, 4'b0010, 4'b0010, 8'hDD, 1'b1, 16'd3};
      tbl[14] = '{4'b0000, 32'hEE00_DD00, 4'b0000, 4'b0000, 8'hDD, 1'b0, 16'd4};

      bus.req   = '0;
      bus.wdata = '0;
      model_reset();
      #3;
      chk("rst_gnt",  32'(bus.gnt), 32'd0);
      chk("rst_ack",  32'(bus.ack), 32'd0);
      chk("rst_q",    32'(bus.q), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_cnt",  32'(bus.wr_count), 32'd0);
      @(negedge clk) reset = 1'b1;

      // Directed table: single request, abort, pointer-ordered picks.
      for (int i = 0; i < 15; i++) begin
         bus.req   = tbl[i].req;
         bus.wdata = tbl[i].wdata;
         tick();
         chk($sformatf("vec%0d_gnt", i),  32'(bus.gnt),  32'(tbl[i].gnt));
         chk($sformatf("vec%0d_ack", i),  32'(bus.ack),  32'(tbl[i].ack));
         chk($sformatf("vec%0d_q", i),    32'(bus.q),    32'(tbl[i].q));
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
         chk($sformatf("vec%0d_cnt", i),  32'(bus.wr_count), 32'(tbl[i].cnt));
      end

      // Round robin with all four requesting.
      do_reset();
      bus.req   = 4'b1111;
      bus.wdata = 32'h4433_2211;
      prev_gnt  = '0;
      viol      = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         g = bus.gnt;
         if (bus.ack != 0 && bus.ack != g) viol++;
         if (g != 0 && prev_gnt == 0)
            for (int b = 0; b < NREQ; b++) if (g[b]) order.push_back(b);
         prev_gnt = g;
      end
      chk("rr_ngrants", 32'(order.size()), 32'd5);
      for (int i = 0; i < 5 && i < order.size(); i++)
         chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));
      chk("rr_cnt", 32'(bus.wr_count), 32'd5);
      chk("rr_ack_vs_gnt", 32'(viol), 32'd0);
      chk("rr_q", 32'(bus.q), 32'h11);

      // Reset asserted between edges while in COMMIT.
      do_reset();
      bus.req   = 4'b0001;
      bus.wdata = 32'h0000_005A;
      tick();
      tick();
      chk("mid_pre_ack", 32'(bus.ack), 32'd1);
      chk("mid_pre_q",   32'(bus.q),   32'h5A);
      #2 reset = 1'b0;
      #1;
      chk("mid_q",    32'(bus.q), 32'd0);
      chk("mid_ack",  32'(bus.ack), 32'd0);
      chk("mid_gnt",  32'(bus.gnt), 32'd0);
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_cnt",  32'(bus.wr_count), 32'd0);
      bus.req = '0;
      model_reset();
      @(negedge clk) reset = 1'b1;

      // Data hold: winner's wdata changes during COMMIT.
      bus.req   = 4'b0010;
      bus.wdata = 32'h0000_7700;
      tick();
      tick();
      bus.wdata = 32'h0000_9900;
      tick();
      chk("hold_q", 32'(bus.q), 32'h77);
      chk("hold_cnt", 32'(bus.wr_count), 32'd1);
      bus.req = '0;
      tick();

      // Counter wrap from a forced 0xFFFF.
      force dut.wr_count_q = 16'hFFFF;
      #1;
      release dut.wr_count_q;
      #1;
      chk("wrap_pre", 32'(bus.wr_count), 32'hFFFF);
      m_cnt = 16'hFFFF;
      bus.req   = 4'b0001;
      bus.wdata = 32'h0000_0042;
      tick();
      tick();
      bus.req = '0;
      tick();
      chk("wrap_cnt", 32'(bus.wr_count), 32'd0);
      chk("wrap_q", 32'(bus.q), 32'h42);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
         bus.wdata = $urandom;
         tick();
         chk_model("rnd");
         chk("rnd_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter WIDTH, default 8: width of the shared register.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-005 Port req, input, NREQ: bit i high means requester i wants to write the shared register.
REQ-006 Port wdata, input, NREQ*WIDTH: requester i write data in bits [i*WIDTH +: WIDTH].
REQ-007 Port gnt, output, NREQ: one-hot grant, or all zero.
REQ-008 Port ack, output, NREQ: one-hot, one-cycle write-complete pulse to the granted requester.
REQ-009 Port q, output, WIDTH: shared register contents.
REQ-010 Port busy, output, 1: high whenever state is not IDLE.
REQ-011 Port wr_count, output, 16: number of completed writes.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, COMMIT.
REQ-013 IDLE, any req bit high at the edge -> GRANT; winner latched; gnt = winner one-hot from the cycle after that edge.
REQ-014 Winner SHALL be the first set req bit searching upward from pointer ptr, wrapping from NREQ-1 to 0.
REQ-015 GRANT, req[winner] still high at the edge -> COMMIT; q loads wdata slice of winner at that same edge.
REQ-016 GRANT, req[winner] low at the edge -> IDLE, abort: no q change, no ack, ptr unchanged, wr_count unchanged.
REQ-017 COMMIT lasts exactly one cycle: ack[winner]=1, gnt[winner]=1; next edge -> IDLE unconditionally.
REQ-018 On the COMMIT->IDLE edge ptr SHALL become (winner+1) mod NREQ and wr_count SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-019 Latency: req sampled high in IDLE at edge N -> gnt after edge N, q updated and ack high after edge N+1, IDLE after edge N+2; minimum 3 cycles per transaction.
REQ-020 Requests arriving or changing for non-winners during GRANT/COMMIT SHALL be ignored until the next IDLE evaluation.
REQ-021 wdata of the winner is sampled only on the GRANT->COMMIT edge; changes at other times have no effect on q.
REQ-022 gnt and ack SHALL be all zero in IDLE; gnt SHALL never have more than one bit set.
REQ-023 A requester holding req high continuously SHALL be re-granted only after every other active requester has been served once (round-robin fairness).
REQ-024 All outputs SHALL be driven from registered state; no combinational path from req or wdata to gnt, ack or q.

Reset
REQ-025 While reset=0: state=IDLE, ptr=0, q=0, gnt=0, ack=0, busy=0, wr_count=0, asynchronously.
REQ-026 Reset asserted in GRANT or COMMIT SHALL abort the transaction: no ack pulse, q cleared to 0, wr_count not incremented.
REQ-027 First arbitration after reset release SHALL start from ptr=0 at the first rising edge with reset=1.

Verification
REQ-028 Single request: reset released, req=0001, wdata[7:0]=0xA5 held -> gnt=0001 after edge 1, q=0xA5 and ack=0001 after edge 2, busy=0 and wr_count=1 after edge 3.
REQ-029 Round-robin: req=1111 held, distinct data per requester -> grant order 0,1,2,3,0; wr_count=5 after 15 cycles; ack never set while gnt differs.
REQ-030 Abort: req=0100 raised, then dropped in GRANT -> IDLE next edge, q unchanged, no ack, ptr still 0; re-raising req=0100 grants requester 2 again.
REQ-031 Mid-transaction reset: reset=0 asserted between edges while in COMMIT -> q=0, ack=0, gnt=0 immediately; wr_count=0.
REQ-032 Wrap: wr_count preloaded to 0xFFFF via 65535 transactions (or forced) -> next commit gives 0x0000.
REQ-033 Data hold: winner changes wdata during COMMIT -> q retains the value sampled at the GRANT->COMMIT edge.
